gain_display_mux: RTL

GAIN_DISPLAY_MUX -- requirements
Module: gain_display_mux

---
 rtl/gain_display_pkg.sv | 47 ++++
 rtl/gain_digit_decoder.sv | 21 ++
 rtl/gain_display_mux.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gain_display_pkg.sv
// Shared definitions for the gain display: digit codes and the active-low
// seven-segment patterns they map to (bit 6 = segment g ... bit 0 = segment a).
package gain_display_pkg;

  // One displayable symbol: decimal digits 0..9, a minus sign, or nothing.
  typedef enum logic [3:0] {
    DC_0     = 4'd0,
    DC_1     = 4'd1,
    DC_2     = 4'd2,
    DC_3     = 4'd3,
    DC_4     = 4'd4,
    DC_5     = 4'd5,
    DC_6     = 4'd6,
    DC_7     = 4'd7,
    DC_8     = 4'd8,
    DC_9     = 4'd9,
    DC_MINUS = 4'd10,
    DC_BLANK = 4'd11
  } digit_code_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Entry n is the pattern for decimal digit n (listed from 9 down to 0).
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Blink counters hold up to 255 frames.
  localparam int BLINK_CNT_W = 8;

  // Turns a 4-bit BCD value into a digit code; anything above 9 shows blank.
  function automatic digit_code_t bcd_to_code(input logic [3:0] d);
    if (d <= 4'd9) return digit_code_t'(d);
    return DC_BLANK;
  endfunction

endpackage

// File: rtl/gain_digit_decoder.sv
// Combinational map from a digit code to its active-low segment pattern.
module gain_digit_decoder
  import gain_display_pkg::*;
(
  input  digit_code_t code_i,
  output logic [6:0]  seg_o
);

  // Decode the symbol; undefined codes fall back to blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      DC_MINUS: seg_o = SEG_MINUS;
      DC_BLANK: seg_o = SEG_BLANK;
      default: begin
        if (code_i <= DC_9) seg_o = SEG_DIGIT[code_i];
      end
    endcase
  end

endmodule

// File: rtl/gain_display_mux.sv
// Multiplexed seven-segment display of CHANNELS signed gains, three digits
// per channel (sign, tens, ones). Gains are snapshotted once per scan frame
// so a frame never mixes old and new values; a channel whose value changed
// blinks for BLINK_FRAMES frames.
module gain_display_mux
  import gain_display_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int GAIN_W       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*GAIN_W-1:0]   gain,
  input  logic [CHANNELS-1:0]          enable,
  output logic [6:0]                   seg,
  output logic [3*CHANNELS-1:0]        dig_n,
  output logic                         frame
);

  localparam int NDIG   = 3 * CHANNELS;
  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BLINK_CNT_W-1:0] BLINK_LOAD = BLINK_CNT_W'(BLINK_FRAMES);

  // |g| in GAIN_W+1 bits so the most negative code maps to its true magnitude.
  function automatic logic [7:0] gain_mag(input logic signed [GAIN_W-1:0] g);
    logic signed [GAIN_W:0] ext;
    ext = {g[GAIN_W-1], g};
    if (g[GAIN_W-1]) ext = -ext;
    return 8'($unsigned(ext));
  endfunction

  // Split a magnitude (at most 64) into {tens, ones}.
  function automatic logic [7:0] dec_split(input logic [7:0] m);
    return {4'(m / 8'd10), 4'(m % 8'd10)};
  endfunction

  // Saturating once-per-frame countdown.
  function automatic logic [BLINK_CNT_W-1:0] blink_dec(input logic [BLINK_CNT_W-1:0] b);
    return (b != '0) ? b - BLINK_CNT_W'(1) : '0;
  endfunction

  // Blink phase: blank while counting and bit 2 is set.
  function automatic logic blink_blank(input logic [BLINK_CNT_W-1:0] b);
    return (b != '0) && b[2];
  endfunction

  // Scan position: tick within a digit, digit position within a channel, channel.
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        pos_q, pos_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              tick_wrap, ch_last, frame_wrap;

  // Per-channel snapshot and blink state.
  logic signed [GAIN_W-1:0]  gain_ch [CHANNELS];
  logic signed [GAIN_W-1:0]  snap_q  [CHANNELS];
  logic [BLINK_CNT_W-1:0]    blink_q [CHANNELS];
  logic                      first_q;

  // Currently selected digit.
  logic signed [GAIN_W-1:0]  sel_gain;
  logic [BLINK_CNT_W-1:0]    sel_blink;
  logic [7:0]                sel_mag;
  logic [7:0]                sel_dec;
  digit_code_t               code_d;
  logic [6:0]                seg_d;
  logic [NDIG-1:0]           dig_n_d;

  // Registered outputs.
  logic [6:0]                seg_q;
  logic [NDIG-1:0]           dig_n_q;
  logic                      frame_q;

  assign tick_wrap  = (tick_q == TICK_W'(SCAN_DIV - 1));
  assign ch_last    = (ch_q == CH_W'(CHANNELS - 1));
  assign frame_wrap = tick_wrap && (pos_q == 2'd2) && ch_last;

  // Unpack the gain bus into per-channel signed values.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      gain_ch[c] = gain[c*GAIN_W +: GAIN_W];
    end
  end

  // Next scan position: tick wraps into the next digit, digit into the next channel.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    pos_d  = pos_q;
    ch_d   = ch_q;
    if (tick_wrap) begin
      tick_d = '0;
      if (pos_q == 2'd2) begin
        pos_d = 2'd0;
        ch_d  = ch_last ? '0 : ch_q + CH_W'(1);
      end else begin
        pos_d = pos_q + 2'd1;
      end
    end
  end

  // Scan counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      pos_q  <= 2'd0;
      ch_q   <= '0;
    end else begin
      tick_q <= tick_d;
      pos_q  <= pos_d;
      ch_q   <= ch_d;
    end
  end

  // Frame-boundary snapshot of all gains and blink counter update.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        snap_q[c]  <= '0;
        blink_q[c] <= '0;
      end
    end else if (frame_wrap) begin
      first_q <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        snap_q[c]  <= gain_ch[c];
        blink_q[c] <= (first_q && (gain_ch[c] != snap_q[c])) ? BLINK_LOAD
                                                             : blink_dec(blink_q[c]);
      end
    end
  end

  // Choose the symbol for the digit being scanned, honouring enable and blink.
  always_comb begin
    sel_gain  = snap_q[ch_q];
    sel_blink = blink_q[ch_q];
    sel_mag   = gain_mag(sel_gain);
    sel_dec   = dec_split(sel_mag);
    code_d    = DC_BLANK;
    case (pos_q)
      2'd0:    code_d = sel_gain[GAIN_W-1] ? DC_MINUS : DC_BLANK;
      2'd1:    code_d = (sel_dec[7:4] == 4'd0) ? DC_BLANK : bcd_to_code(sel_dec[7:4]);
      default: code_d = bcd_to_code(sel_dec[3:0]);
    endcase
    if (!enable[ch_q] || blink_blank(sel_blink)) code_d = DC_BLANK;
  end

  gain_digit_decoder u_decoder (
    .code_i (code_d),
    .seg_o  (seg_d)
  );

  // Digit select: one active-low line, none during the first tick of each digit.
  always_comb begin
    dig_n_d = '1;
    if (tick_q != '0) begin
      for (int d = 0; d < NDIG; d++) begin
        if ((ch_q == CH_W'(d / 3)) && (pos_q == 2'(d % 3))) dig_n_d[d] = 1'b0;
      end
    end
  end

  // Output register stage, one cycle behind the scan position.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= SEG_BLANK;
      dig_n_q <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      dig_n_q <= dig_n_d;
      frame_q <= frame_wrap;
    end
  end

  assign seg   = seg_q;
  assign dig_n = dig_n_q;
  assign frame = frame_q;

endmodule
